lv0_notify_q: RTL and testbench

LV0_NOTIFY_Q -- requirements
Module: lv0_notify_q

---
 rtl/lv0_notify_q.sv | 106 ++++++++++
 tb/tb_lv0_notify_q.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/lv0_notify_q.sv
// Level-0 change notification queue: per-context coalescing FIFO with drop
// accounting. One entry per context; repeat notifications update in place.
package v_pkg;
    typedef logic [6:0]  id_t;
    typedef logic [31:0] key_t;
    typedef logic [15:0] size_t;

    typedef struct packed {
        id_t   prod_id;
        key_t  key;
        size_t size;
    } ntf_ent_t;
endpackage

module lv0_notify_q #(
    parameter int CONTEXT_N = 128,
    parameter int DEPTH_N   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_lv0_vld,
    input  v_pkg::id_t                   i_lv0_prod_id,
    input  v_pkg::key_t                  i_lv0_key,
    input  v_pkg::size_t                 i_lv0_size,
    output logic                         o_ntf_vld,
    input  logic                         i_ntf_rdy,
    output v_pkg::id_t                   o_ntf_prod_id,
    output v_pkg::key_t                  o_ntf_key,
    output v_pkg::size_t                 o_ntf_size,
    output logic [$clog2(DEPTH_N+1)-1:0] o_occ,
    output logic                         o_ovf,
    output logic [15:0]                  o_drop_cnt
);
    localparam int PW = $clog2(DEPTH_N);
    localparam int OW = $clog2(DEPTH_N+1);
    localparam logic [OW-1:0] DEPTH_OCC = OW'(DEPTH_N);

    v_pkg::ntf_ent_t      mem [DEPTH_N];
    logic [PW-1:0]        slot [CONTEXT_N];
    logic [CONTEXT_N-1:0] pending;
    logic [PW-1:0]        head, tail;
    logic [OW-1:0]        occ, occ_ap;
    logic [15:0]          drop_cnt;
    logic                 ovf;
    logic                 pop, pend_ap, push, coal, drop;

    // Pop is resolved first: an ID whose head entry leaves this cycle is
    // treated as not pending, so its new arrival becomes a fresh tail entry.
    always_comb begin
        pop     = (occ != '0) && i_ntf_rdy;
        occ_ap  = occ - OW'(pop);
        pend_ap = pending[i_lv0_prod_id] &&
                  !(pop && (mem[head].prod_id == i_lv0_prod_id));
        coal    = i_lv0_vld && pend_ap;
        push    = i_lv0_vld && !pend_ap && (occ_ap < DEPTH_OCC);
        drop    = i_lv0_vld && !pend_ap && !(occ_ap < DEPTH_OCC);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head     <= '0;
            tail     <= '0;
            occ      <= '0;
            pending  <= '0;
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (pop) begin
                head                     <= head + 1'b1;
                pending[mem[head].prod_id] <= 1'b0;
            end
            // Later assignment wins when the popped ID re-arrives this cycle.
            if (push) begin
                tail                   <= tail + 1'b1;
                pending[i_lv0_prod_id] <= 1'b1;
            end
            occ <= occ_ap + OW'(push);
            if (drop) begin
                ovf <= 1'b1;
                if (drop_cnt != 16'hFFFF)
                    drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    // Payload storage carries no reset; occupancy and pending bits qualify it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (push) begin
                mem[tail]           <= '{prod_id: i_lv0_prod_id, key: i_lv0_key, size: i_lv0_size};
                slot[i_lv0_prod_id] <= tail;
            end else if (coal) begin
                mem[slot[i_lv0_prod_id]].key  <= i_lv0_key;
                mem[slot[i_lv0_prod_id]].size <= i_lv0_size;
            end
        end
    end

    assign o_ntf_vld     = (occ != '0);
    assign o_ntf_prod_id = mem[head].prod_id;
    assign o_ntf_key     = mem[head].key;
    assign o_ntf_size    = mem[head].size;
    assign o_occ         = occ;
    assign o_ovf         = ovf;
    assign o_drop_cnt    = drop_cnt;
endmodule

// File: tb/tb_lv0_notify_q.sv
// Scoreboard bench for lv0_notify_q: a behavioural coalescing queue predicts
// head payload, occupancy and drop state; outputs checked on the falling edge.
module tb_lv0_notify_q;
    localparam int DEPTH_N = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_lv0_vld = 1'b0;
    logic [6:0]  i_lv0_prod_id = '0;
    logic [31:0] i_lv0_key = '0;
    logic [15:0] i_lv0_size = '0;
    logic        o_ntf_vld;
    logic        i_ntf_rdy = 1'b0;
    logic [6:0]  o_ntf_prod_id;
    logic [31:0] o_ntf_key;
    logic [15:0] o_ntf_size;
    logic [3:0]  o_occ;
    logic        o_ovf;
    logic [15:0] o_drop_cnt;

    lv0_notify_q #(.CONTEXT_N(128), .DEPTH_N(DEPTH_N)) dut (
        .clk(clk), .rst(rst),
        .i_lv0_vld(i_lv0_vld), .i_lv0_prod_id(i_lv0_prod_id),
        .i_lv0_key(i_lv0_key), .i_lv0_size(i_lv0_size),
        .o_ntf_vld(o_ntf_vld), .i_ntf_rdy(i_ntf_rdy),
        .o_ntf_prod_id(o_ntf_prod_id), .o_ntf_key(o_ntf_key),
        .o_ntf_size(o_ntf_size), .o_occ(o_occ), .o_ovf(o_ovf),
        .o_drop_cnt(o_drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  id;
        logic [31:0] key;
        logic [15:0] size;
    } ent_t;

    ent_t        mq[$];
    logic        m_ovf  = 1'b0;
    logic [15:0] m_drop = '0;
    int          n_chk  = 0;
    int          n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".vld"},  32'(o_ntf_vld), 32'(mq.size() != 0));
        chk({tag, ".occ"},  32'(o_occ), 32'(mq.size()));
        chk({tag, ".ovf"},  32'(o_ovf), 32'(m_ovf));
        chk({tag, ".drop"}, 32'(o_drop_cnt), 32'(m_drop));
        if (mq.size() != 0) begin
            chk({tag, ".id"},   32'(o_ntf_prod_id), 32'(mq[0].id));
            chk({tag, ".key"},  32'(o_ntf_key), mq[0].key);
            chk({tag, ".size"}, 32'(o_ntf_size), 32'(mq[0].size));
        end
    endtask

    // One clock: check current outputs, drive, then advance the model at the edge.
    task automatic step(input string tag, input logic r, input logic v, input int id,
                        input logic [31:0] key, input int sz, input logic rd);
        int found;
        @(negedge clk);
        check_outputs(tag);
        rst = r; i_lv0_vld = v; i_lv0_prod_id = 7'(id);
        i_lv0_key = key; i_lv0_size = 16'(sz); i_ntf_rdy = rd;
        @(posedge clk);
        if (r) begin
            mq.delete(); m_ovf = 1'b0; m_drop = '0;
        end else begin
            if (rd && mq.size() != 0) void'(mq.pop_front());
            if (v) begin
                found = -1;
                foreach (mq[i]) if (mq[i].id == 7'(id)) found = i;
                if (found >= 0) begin
                    mq[found].key = key; mq[found].size = 16'(sz);
                end else if (mq.size() < DEPTH_N) begin
                    mq.push_back('{id: 7'(id), key: key, size: 16'(sz)});
                end else begin
                    m_ovf = 1'b1;
                    if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
                end
            end
        end
    endtask

    task automatic idle(input string tag, input logic rd, input int n);
        for (int k = 0; k < n; k++) step(tag, 1'b0, 1'b0, 0, 0, 0, rd);
    endtask

    initial begin
        step("rst0", 1'b1, 1'b0, 0, 0, 0, 1'b0);
        step("rst1", 1'b1, 1'b0, 0, 0, 0, 1'b0);

        // Single push into empty queue, consumer ready.
        step("lat_push", 1'b0, 1'b1, 5, 32'h10, 3, 1'b1);
        idle("lat", 1'b1, 2);

        // Coalesce while stalled, then one transfer.
        step("coal_a", 1'b0, 1'b1, 5, 32'h10, 3, 1'b0);
        step("coal_b", 1'b0, 1'b1, 5, 32'h11, 7, 1'b0);
        idle("coal_hold", 1'b0, 1);
        idle("coal_drain", 1'b1, 2);

        // Fill to depth, then drop a new ID, then drain in order.
        for (int i = 0; i < 8; i++) step("fill", 1'b0, 1'b1, i, 32'h100 + i, i, 1'b0);
        step("ovf_push", 1'b0, 1'b1, 8, 32'h108, 8, 1'b0);
        idle("ovf_hold", 1'b0, 1);
        idle("ovf_drain", 1'b1, 9);

        // Full queue with simultaneous pop accepts a new ID.
        step("rst_full", 1'b1, 1'b0, 0, 0, 0, 1'b0);
        for (int i = 0; i < 8; i++) step("fill2", 1'b0, 1'b1, i, 32'h200 + i, i, 1'b0);
        step("full_pop_push", 1'b0, 1'b1, 9, 32'h209, 9, 1'b1);
        idle("full_hold", 1'b0, 1);
        idle("full_drain", 1'b1, 9);

        // Same ID arrives as its head entry pops: new tail entry.
        step("rst_same", 1'b1, 1'b0, 0, 0, 0, 1'b0);
        step("same_a", 1'b0, 1'b1, 3, 32'h21, 1, 1'b0);
        step("same_b", 1'b0, 1'b1, 4, 32'h40, 2, 1'b0);
        step("same_pop", 1'b0, 1'b1, 3, 32'h22, 5, 1'b1);
        idle("same_hold", 1'b0, 1);
        idle("same_drain", 1'b1, 3);

        // Reset with entries queued and a coincident input.
        for (int i = 0; i < 5; i++) step("pre_rst", 1'b0, 1'b1, 20 + i, 32'h300 + i, i, 1'b0);
        step("pre_rst_drop", 1'b0, 1'b0, 0, 0, 0, 1'b0);
        step("rst_busy", 1'b1, 1'b1, 30, 32'h3FF, 1, 1'b1);
        idle("post_rst", 1'b0, 1);

        // Random traffic over a small ID space to exercise coalesce and drops.
        for (int k = 0; k < 400; k++)
            step("rnd", 1'b0, 1'($urandom_range(0, 3) != 0), $urandom_range(0, 11),
                 $urandom, $urandom_range(0, 65535), 1'($urandom_range(0, 2) == 0));
        idle("rnd_drain", 1'b1, 10);

        @(negedge clk);
        check_outputs("final");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
